// File: rtl/riscv_alu_pkg.sv
// Shared encodings for the ALU decoder and the iterative multiply/divide unit.
// Holds the ALU op classes, ALU control words, RV32M funct3 values and the MDU state type.
package riscv_alu_pkg;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD   = 2'b11;

  // ALU control word is {funct3, sub/sra}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic f3_signed_a(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: f3_signed_a = 1'b1;
      default:                                    f3_signed_a = 1'b0;
    endcase
  endfunction

  function automatic logic f3_signed_b(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: f3_signed_b = 1'b1;
      default:                         f3_signed_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV32M unit: one bit per cycle shift-add multiply and restoring divide on
// operand magnitudes, with a final sign-fix cycle. Divide-by-zero and overflow skip the loop.
module mdu_iterative
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e          state, state_next;
  logic [CW-1:0]       count;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;
  logic [2:0]          f3;
  logic                neg_a, neg_b, bypass;

  logic                accept, sa, sb, div_zero, overflow, special;
  logic [XLEN-1:0]     mag_a, mag_b, special_val;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0]     quo, rem, fix_val;

  assign busy = (state != MDU_IDLE);

  // Operand conditioning and special-case detection for an incoming request
  always_comb begin
    accept   = (state == MDU_IDLE) && start && !flush && !done;
    sa       = f3_signed_a(funct3) && op_a[XLEN-1];
    sb       = f3_signed_b(funct3) && op_b[XLEN-1];
    mag_a    = sa ? (~op_a + {{(XLEN-1){1'b0}}, 1'b1}) : op_a;
    mag_b    = sb ? (~op_b + {{(XLEN-1){1'b0}}, 1'b1}) : op_b;
    div_zero = (op_b == {XLEN{1'b0}});
    overflow = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
    special  = funct3[2] && (div_zero || overflow);
    // REM variants have funct3[1] set
    if (div_zero) begin
      special_val = funct3[1] ? op_a : {XLEN{1'b1}};
    end else begin
      special_val = funct3[1] ? {XLEN{1'b0}} : op_a;
    end
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (div_diff[XLEN]) begin
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  // Sign fix and result selection applied in the FIX cycle
  always_comb begin
    prod = (neg_a ^ neg_b) ? (~acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    if (bypass) begin
      fix_val = acc[XLEN-1:0];
    end else begin
      case (f3)
        F3_MUL:                       fix_val = prod[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:              fix_val = (neg_a ^ neg_b) ? (~quo + {{(XLEN-1){1'b0}}, 1'b1}) : quo;
        F3_REM, F3_REMU:              fix_val = neg_a ? (~rem + {{(XLEN-1){1'b0}}, 1'b1}) : rem;
        default:                      fix_val = {XLEN{1'b0}};
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: begin
        if (accept) begin
          state_next = special ? MDU_FIX : MDU_CALC;
        end else begin
          state_next = MDU_IDLE;
        end
      end
      MDU_CALC: begin
        if (flush) begin
          state_next = MDU_IDLE;
        end else if (count == {CW{1'b0}}) begin
          state_next = MDU_FIX;
        end else begin
          state_next = MDU_CALC;
        end
      end
      MDU_FIX:  state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  // State, datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= MDU_IDLE;
      count  <= {CW{1'b0}};
      acc    <= {(2*XLEN){1'b0}};
      opnd   <= {XLEN{1'b0}};
      f3     <= 3'b000;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      bypass <= 1'b0;
      done   <= 1'b0;
      result <= {XLEN{1'b0}};
    end else begin
      state <= state_next;
      done  <= (state == MDU_FIX) && !flush;
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            f3     <= funct3;
            neg_a  <= sa;
            neg_b  <= sb;
            count  <= CW'(XLEN-1);
            bypass <= special;
            if (special) begin
              opnd <= {XLEN{1'b0}};
              acc  <= {{XLEN{1'b0}}, special_val};
            end else begin
              // multiply keeps the multiplier in acc low; divide keeps the dividend there
              opnd <= funct3[2] ? mag_b : mag_a;
              acc  <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
            end
          end
        end
        MDU_CALC: begin
          if (!flush) begin
            acc   <= f3[2] ? div_next : mul_next;
            count <= count - CW'(1);
          end
        end
        MDU_FIX: begin
          if (!flush) begin
            result <= fix_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_decoder_mdu.sv
// ALU control decode for RV32I plus RV32M detection; the M-ops are executed by the
// iterative multiply/divide unit instantiated here.
module alu_decoder_mdu
  import riscv_alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit M_EXT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_bit5,
  input  logic            funct7_bit0,
  input  logic            is_rtype,
  input  logic            mdu_start,
  input  logic            mdu_flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      alu_control,
  output logic            is_mdu,
  output logic            mdu_busy,
  output logic            mdu_done,
  output logic [XLEN-1:0] mdu_result
);

  logic sub_sra;

  // Combinational ALU decode; immediates only carry the sub/sra bit for shifts (funct3 101)
  always_comb begin
    is_mdu  = M_EXT_EN && (alu_op == ALU_OP_RTYPE) && is_rtype && funct7_bit0;
    sub_sra = (is_rtype || (funct3 == 3'b101)) ? funct7_bit5 : 1'b0;
    if (is_mdu) begin
      alu_control = ALU_ADD;
    end else begin
      case (alu_op)
        ALU_OP_BRANCH, ALU_OP_RTYPE: alu_control = {funct3, sub_sra};
        ALU_OP_ADD, ALU_OP_RSVD:     alu_control = ALU_ADD;
        default:                     alu_control = ALU_ADD;
      endcase
    end
  end

  mdu_iterative #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mdu_start && is_mdu),
    .flush  (mdu_flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_result)
  );

endmodule

// File: tb/tb_alu_decoder_mdu.sv
// Directed bench for alu_decoder_mdu: decode vectors, MDU results/latencies, special cases,
// start-while-busy, flush and mid-operation reset.
module tb_alu_decoder_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_bit5, funct7_bit0, is_rtype;
  logic        mdu_start, mdu_flush;
  logic [31:0] op_a, op_b;
  logic [3:0]  alu_control;
  logic        is_mdu, mdu_busy, mdu_done;
  logic [31:0] mdu_result;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_decoder_mdu #(.XLEN(32), .M_EXT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct3(funct3),
    .funct7_bit5(funct7_bit5), .funct7_bit0(funct7_bit0), .is_rtype(is_rtype),
    .mdu_start(mdu_start), .mdu_flush(mdu_flush), .op_a(op_a), .op_b(op_b),
    .alu_control(alu_control), .is_mdu(is_mdu), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .mdu_result(mdu_result)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic decode_vec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                            input logic b5, input logic b0, input logic rt,
                            input logic [3:0] exp_ctl, input logic exp_mdu);
    alu_op = op; funct3 = f3; funct7_bit5 = b5; funct7_bit0 = b0; is_rtype = rt;
    #1;
    check_eq({tag, "_ctl"}, {28'd0, alu_control}, {28'd0, exp_ctl});
    check_eq({tag, "_mdu"}, {31'd0, is_mdu}, {31'd0, exp_mdu});
  endtask

  task automatic set_mop(input logic [2:0] f3);
    alu_op = 2'b10; is_rtype = 1'b1; funct7_bit0 = 1'b1; funct7_bit5 = 1'b0; funct3 = f3;
  endtask

  // Launch an op at edge N and count edges until done; optionally poke start while busy
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input bit poke);
    int lat;
    @(negedge clk);
    set_mop(f3); op_a = a; op_b = b; mdu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mdu_start = 1'b0; op_a = 32'h0000_0000; op_b = 32'h0000_0000;
    check_eq({tag, "_busy"}, {31'd0, mdu_busy}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 45; k++) begin
      if (poke && k == 5) begin
        mdu_start = 1'b1; op_a = 32'd50; op_b = 32'd5;
      end
      @(posedge clk);
      @(negedge clk);
      mdu_start = 1'b0;
      if (mdu_done) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, mdu_result, exp_res);
    check_eq({tag, "_idle_at_done"}, {31'd0, mdu_busy}, 32'd0);
  endtask

  // Start a long multiply, then flush or reset so it lands on edge N+10
  task automatic abort_op(input string tag, input bit use_reset, input logic [31:0] exp_res);
    int dones;
    @(negedge clk);
    set_mop(3'b000); op_a = 32'd3; op_b = 32'd5; mdu_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mdu_start = 1'b0;
    repeat (9) @(negedge clk);
    if (use_reset) rst_n = 1'b0;
    else           mdu_flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; mdu_flush = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, mdu_busy}, 32'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mdu_done) dones++;
    end
    check_eq({tag, "_no_done"}, dones, 0);
    check_eq({tag, "_res"}, mdu_result, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; alu_op = 2'b00; funct3 = 3'b000; funct7_bit5 = 1'b0; funct7_bit0 = 1'b0;
    is_rtype = 1'b0; mdu_start = 1'b0; mdu_flush = 1'b0; op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, mdu_busy}, 32'd0);
    check_eq("rst_done", {31'd0, mdu_done}, 32'd0);
    check_eq("rst_res", mdu_result, 32'h0000_0000);
    rst_n = 1'b1;

    decode_vec("addi_imm10", 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    decode_vec("sub",        2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0);
    decode_vec("sra",        2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b0);
    decode_vec("srai",       2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0);
    decode_vec("ori",        2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 4'b1100, 1'b0);
    decode_vec("addr",       2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
    decode_vec("branch",     2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    decode_vec("rsvd",       2'b11, 3'b111, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    decode_vec("mop_div",    2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);

    // start without an M-op decode must be ignored
    @(negedge clk);
    alu_op = 2'b00; is_rtype = 1'b1; funct7_bit0 = 1'b1; op_b = 32'd3; mdu_start = 1'b1;
    @(negedge clk);
    mdu_start = 1'b0;
    check_eq("start_not_mdu", {31'd0, mdu_busy}, 32'd0);

    // flush in the same cycle as start wins
    set_mop(3'b101); op_a = 32'd9; op_b = 32'd3; mdu_start = 1'b1; mdu_flush = 1'b1;
    @(negedge clk);
    mdu_start = 1'b0; mdu_flush = 1'b0;
    check_eq("flush_beats_start", {31'd0, mdu_busy}, 32'd0);

    run_op("mulh",     3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("mul",      3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  1'b0);
    run_op("remu_z",   3'b111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1,  1'b0);
    run_op("div_z",    3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1,  1'b0);
    run_op("divu_poke",3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b1);
    run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 1'b0);

    abort_op("flush_mid", 1'b0, 32'hFFFF_FFFD);
    abort_op("reset_mid", 1'b1, 32'h0000_0000);

    run_op("divu_after", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
